ldmr_seq_ctrl: RTL and testbench

Load-matrix-register sequencer: accepts one load command (destination register, DDR address, beat count) and issues a single burst read to the DDR interface. It counts returned beats and drives the one-hot `ldmr_mrx__sel_o` destination select consumed by the matrix-register hub. After the hub's registered write stage has delivered the final beat, it signals completion. It sits between the instruction decode stage and the hub/DDR interface pair.

---
 rtl/ldmr_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_ldmr_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldmr_seq_ctrl.sv
// Purpose  : load-matrix-register sequencer; one command -> one DDR burst read, one-hot hub select, done pulse.
// Latency  : accept T -> rd_req/sel at T+1; final beat L -> DRAIN L+1 -> done L+2 -> cmd_rdy L+3; no-op/invalid: done T+1.
// Backpress: cmd_rdy only in IDLE; rd_req held until rd_ack; beats cannot be stalled, out-of-window beats flag err.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   ldmr__cmd_{vld,rdy,dst,addr,len}  load command from decode (dst 0..4 valid, len 0 = no-op)
//   ldmr_ddrintf__rd_{req,addr,len}   burst read request to DDR interface, held until rd_ack_i
//   ldmr_ddrintf__rdata_act_i         one returned data beat this cycle
//   ldmr_mrx__sel_o                   one-hot destination select to the matrix-register hub
//   ldmr__{busy,done,err}_o           status: not-idle, one-cycle completion, sticky error
module ldmr_seq_ctrl #(
    parameter int BEAT_CNT_WTH   = 8,
    parameter int DDRIF_ADDR_WTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ldmr__cmd_vld_i,
    output logic                      ldmr__cmd_rdy_o,
    input  logic [2:0]                ldmr__cmd_dst_i,
    input  logic [DDRIF_ADDR_WTH-1:0] ldmr__cmd_addr_i,
    input  logic [BEAT_CNT_WTH-1:0]   ldmr__cmd_len_i,
    output logic                      ldmr_ddrintf__rd_req_o,
    output logic [DDRIF_ADDR_WTH-1:0] ldmr_ddrintf__rd_addr_o,
    output logic [BEAT_CNT_WTH-1:0]   ldmr_ddrintf__rd_len_o,
    input  logic                      ldmr_ddrintf__rd_ack_i,
    input  logic                      ldmr_ddrintf__rdata_act_i,
    output logic [4:0]                ldmr_mrx__sel_o,
    output logic                      ldmr__busy_o,
    output logic                      ldmr__done_o,
    output logic                      ldmr__err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_RECV  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [2:0]                  dst_q;
    logic [DDRIF_ADDR_WTH-1:0]   addr_q;
    logic [BEAT_CNT_WTH-1:0]     len_q;
    logic [BEAT_CNT_WTH-1:0]     rem_q, rem_d;
    logic                        err_q, err_d;

    logic accept;
    logic beat;
    logic stray;
    logic last_beat;

    assign accept = (state_q == S_IDLE) && ldmr__cmd_vld_i;

    // A beat is only legitimate once the request is acknowledged; the ack
    // cycle itself may already carry data.
    assign beat = ldmr_ddrintf__rdata_act_i &&
                  ((state_q == S_RECV) || ((state_q == S_REQ) && ldmr_ddrintf__rd_ack_i));
    assign stray     = ldmr_ddrintf__rdata_act_i && !beat;
    assign last_beat = beat && (rem_q == BEAT_CNT_WTH'(1));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d = ldmr__cmd_len_i;
                    err_d = 1'b0;
                    if (ldmr__cmd_dst_i > 3'd4) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (ldmr__cmd_len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (ldmr_ddrintf__rd_ack_i) begin
                    state_d = last_beat ? S_DRAIN : S_RECV;
                end
            end
            S_RECV: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            // One cycle for the hub's registered write of the final beat.
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // rem never underflows: the last beat always moves the FSM out of
        // the counting states.
        if (beat) begin
            rem_d = rem_q - BEAT_CNT_WTH'(1);
        end
        // A stray beat wins over the clear-on-accept in the same cycle.
        if (stray) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            if (accept) begin
                dst_q  <= ldmr__cmd_dst_i;
                addr_q <= ldmr__cmd_addr_i;
                len_q  <= ldmr__cmd_len_i;
            end
        end
    end

    // All outputs decode registered state only, so an async reset clears
    // them immediately and sel can only change on a state transition.
    always_comb begin
        ldmr_mrx__sel_o = '0;
        if ((state_q == S_REQ) || (state_q == S_RECV) || (state_q == S_DRAIN)) begin
            ldmr_mrx__sel_o = 5'b00001 << dst_q;
        end
    end

    assign ldmr__cmd_rdy_o         = (state_q == S_IDLE);
    assign ldmr__busy_o            = (state_q != S_IDLE);
    assign ldmr__done_o            = (state_q == S_DONE);
    assign ldmr__err_o             = err_q;
    assign ldmr_ddrintf__rd_req_o  = (state_q == S_REQ);
    assign ldmr_ddrintf__rd_addr_o = addr_q;
    assign ldmr_ddrintf__rd_len_o  = len_q;

endmodule

// File: tb/tb_ldmr_seq_ctrl.sv
// Purpose  : directed self-checking bench for ldmr_seq_ctrl.
// Latency  : inputs driven and outputs sampled 1 time unit after each rising clock edge.
// Backpress: DDR ack and beats are scripted per cycle; no waits on DUT events.
module tb_ldmr_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [2:0]  cmd_dst;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rdata_act;
    logic [4:0]  sel;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ldmr_seq_ctrl #(.BEAT_CNT_WTH(8), .DDRIF_ADDR_WTH(32)) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .ldmr__cmd_vld_i           (cmd_vld),
        .ldmr__cmd_rdy_o           (cmd_rdy),
        .ldmr__cmd_dst_i           (cmd_dst),
        .ldmr__cmd_addr_i          (cmd_addr),
        .ldmr__cmd_len_i           (cmd_len),
        .ldmr_ddrintf__rd_req_o    (rd_req),
        .ldmr_ddrintf__rd_addr_o   (rd_addr),
        .ldmr_ddrintf__rd_len_o    (rd_len),
        .ldmr_ddrintf__rd_ack_i    (rd_ack),
        .ldmr_ddrintf__rdata_act_i (rdata_act),
        .ldmr_mrx__sel_o           (sel),
        .ldmr__busy_o              (busy),
        .ldmr__done_o              (done),
        .ldmr__err_o               (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Accept a command in the current (idle) cycle and advance one cycle.
    task automatic issue(input logic [2:0] dst, input logic [31:0] addr, input logic [7:0] len);
        cmd_vld  = 1'b1;
        cmd_dst  = dst;
        cmd_addr = addr;
        cmd_len  = len;
        tick();
        cmd_vld  = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; cmd_vld = 1'b0; cmd_dst = '0; cmd_addr = '0; cmd_len = '0;
        rd_ack = 1'b0; rdata_act = 1'b0;
        #12;
        // ---- reset state ----
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_rd_req",  32'(rd_req),  32'd0);
        chk("rst_sel",     32'(sel),     32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_rd_addr", rd_addr,      32'd0);
        chk("rst_rd_len",  32'(rd_len),  32'd0);
        rst_i = 1'b0;
        tick();

        // ---- single load: dst=2 addr=0x1000 len=4, ack 3 cycles after req ----
        issue(3'd2, 32'h0000_1000, 8'd4);
        chk("t1_rd_req",  32'(rd_req),  32'd1);
        chk("t1_sel",     32'(sel),     32'b00100);
        chk("t1_rd_len",  32'(rd_len),  32'd4);
        chk("t1_rd_addr", rd_addr,      32'h1000);
        chk("t1_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("t1_busy",    32'(busy),    32'd1);
        tick(); tick(); tick();
        chk("t1_req_held", 32'(rd_req), 32'd1);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("t1_req_drop", 32'(rd_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rdata_act = 1'b1;
            chk("t1_sel_burst", 32'(sel), 32'b00100);
            chk("t1_no_done",   32'(done), 32'd0);
            tick();
        end
        rdata_act = 1'b0;
        chk("t1_drain_sel",  32'(sel),  32'b00100);
        chk("t1_drain_done", 32'(done), 32'd0);
        tick();
        chk("t1_done",      32'(done),    32'd1);
        chk("t1_done_sel",  32'(sel),     32'd0);
        chk("t1_done_rdy",  32'(cmd_rdy), 32'd0);
        tick();
        chk("t1_idle_rdy",  32'(cmd_rdy), 32'd1);
        chk("t1_idle_done", 32'(done),    32'd0);
        chk("t1_err",       32'(err),     32'd0);

        // ---- gapped beats, one in the ack cycle: dst=3 len=3 ----
        issue(3'd3, 32'h0000_2040, 8'd3);
        chk("t2_sel", 32'(sel), 32'b01000);
        rd_ack = 1'b1; rdata_act = 1'b1;
        tick();
        rd_ack = 1'b0; rdata_act = 1'b0;
        tick(); tick();
        rdata_act = 1'b1;
        tick();
        rdata_act = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_sel_gap", 32'(sel), 32'b01000);
            chk("t2_no_done", 32'(done), 32'd0);
            tick();
        end
        rdata_act = 1'b1;
        tick();
        rdata_act = 1'b0;
        chk("t2_drain_sel", 32'(sel),  32'b01000);
        chk("t2_drain_nd",  32'(done), 32'd0);
        tick();
        chk("t2_done", 32'(done), 32'd1);
        tick();
        chk("t2_single_done", 32'(done),    32'd0);
        chk("t2_rdy",         32'(cmd_rdy), 32'd1);
        chk("t2_err",         32'(err),     32'd0);

        // ---- zero-length no-op: dst=0 len=0 ----
        issue(3'd0, 32'h0000_3000, 8'd0);
        chk("t3_done",   32'(done),   32'd1);
        chk("t3_rd_req", 32'(rd_req), 32'd0);
        chk("t3_sel",    32'(sel),    32'd0);
        chk("t3_err",    32'(err),    32'd0);
        tick();
        chk("t3_rdy",    32'(cmd_rdy), 32'd1);

        // ---- invalid destination: dst=6 len=5 ----
        issue(3'd6, 32'h0000_4000, 8'd5);
        chk("t4_done",   32'(done),   32'd1);
        chk("t4_err",    32'(err),    32'd1);
        chk("t4_rd_req", 32'(rd_req), 32'd0);
        tick();
        chk("t4_rdy",        32'(cmd_rdy), 32'd1);
        chk("t4_err_sticky", 32'(err),     32'd1);

        // ---- next valid accept clears err: dst=4 len=1, beat with ack ----
        issue(3'd4, 32'h0000_5000, 8'd1);
        chk("t5_err_clr", 32'(err), 32'd0);
        chk("t5_sel",     32'(sel), 32'b10000);
        rd_ack = 1'b1; rdata_act = 1'b1;
        tick();
        rd_ack = 1'b0; rdata_act = 1'b0;
        chk("t5_drain_sel", 32'(sel), 32'b10000);
        tick();
        chk("t5_done", 32'(done), 32'd1);
        tick();
        chk("t5_rdy", 32'(cmd_rdy), 32'd1);

        // ---- stray beat while idle ----
        rdata_act = 1'b1;
        tick();
        rdata_act = 1'b0;
        chk("t6_err",  32'(err),     32'd1);
        chk("t6_rdy",  32'(cmd_rdy), 32'd1);
        chk("t6_busy", 32'(busy),    32'd0);
        chk("t6_sel",  32'(sel),     32'd0);

        // ---- reset mid-burst: dst=1 len=8, reset after 3 beats ----
        issue(3'd1, 32'h0000_6000, 8'd8);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rdata_act = 1'b1;
        tick(); tick(); tick();
        rdata_act = 1'b0;
        chk("t7_pre_sel", 32'(sel), 32'b00010);
        #2 rst_i = 1'b1;
        #1;
        chk("t7_rst_sel",    32'(sel),     32'd0);
        chk("t7_rst_busy",   32'(busy),    32'd0);
        chk("t7_rst_req",    32'(rd_req),  32'd0);
        chk("t7_rst_done",   32'(done),    32'd0);
        chk("t7_rst_err",    32'(err),     32'd0);
        chk("t7_rst_rd_len", 32'(rd_len),  32'd0);
        #1 rst_i = 1'b0;
        tick();
        chk("t7_rdy", 32'(cmd_rdy), 32'd1);
        chk("t7_no_done", 32'(done), 32'd0);

        // ---- fresh len=2 command after reset ----
        issue(3'd0, 32'h0000_7000, 8'd2);
        chk("t8_sel",    32'(sel),    32'b00001);
        chk("t8_rd_len", 32'(rd_len), 32'd2);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        rdata_act = 1'b1;
        tick();
        chk("t8_mid_no_done", 32'(done), 32'd0);
        tick();
        rdata_act = 1'b0;
        chk("t8_drain_sel", 32'(sel),  32'b00001);
        chk("t8_drain_nd",  32'(done), 32'd0);
        tick();
        chk("t8_done", 32'(done), 32'd1);
        tick();
        chk("t8_rdy", 32'(cmd_rdy), 32'd1);
        chk("t8_err", 32'(err),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
